// File: rtl/hazard_pkg.sv
// hazard_pkg
// Shared definitions for the pipeline hazard controller:
//   - controller state encoding (RUN / MULTI)
//   - PC source select encodings driven onto PCSrcSel
//   - architectural zero register number (never a real hazard source)
package hazard_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    MULTI = 1'b1
  } state_t;

  localparam logic [1:0] PCSRC_SEQ = 2'd0;
  localparam logic [1:0] PCSRC_BR  = 2'd1;
  localparam logic [1:0] PCSRC_J   = 2'd2;
  localparam logic [1:0] PCSRC_JR  = 2'd3;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_use_detector.sv
// load_use_detector
// Purely combinational load-use hazard compare. Flags when the instruction
// in EX is a load whose destination is read by the instruction in ID.
// Ports:
//   i_idExMemRead  EX-stage instruction is a load
//   i_idExRd       destination register of the EX-stage instruction
//   i_ifIdRs       rs field of the ID-stage instruction
//   i_ifIdRt       rt field of the ID-stage instruction
//   i_ifIdUsesRt   ID-stage instruction actually reads rt
//   o_loadUse      hazard present this cycle
module load_use_detector
  import hazard_pkg::*;
(
  input  logic       i_idExMemRead,
  input  logic [4:0] i_idExRd,
  input  logic [4:0] i_ifIdRs,
  input  logic [4:0] i_ifIdRt,
  input  logic       i_ifIdUsesRt,
  output logic       o_loadUse
);

  logic w_rsMatch;
  logic w_rtMatch;

  assign w_rsMatch = (i_idExRd == i_ifIdRs);
  assign w_rtMatch = i_ifIdUsesRt && (i_idExRd == i_ifIdRt);

  // Writes to $zero are discarded, so a load targeting it never blocks ID.
  assign o_loadUse = i_idExMemRead && (i_idExRd != REG_ZERO) && (w_rsMatch || w_rtMatch);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
// Central stall/flush sequencer for the 5-stage MIPS pipeline. Drives the
// load enables and bubble controls of PC, IF/ID, ID/EX and EX/MEM plus the
// PC source select. Priority: redirect > multi-cycle hold > load-use stall.
// Ports:
//   Clk, Rst_n            clock (state on posedge), async active-low reset
//   IfIdRs/IfIdRt/IfIdUsesRt  ID-stage source operands
//   IdExMemRead/IdExRd    EX-stage load flag and destination
//   ExMulStart            EX-stage op is multi-cycle (first EX cycle)
//   MemBranch/MemZero/MemJump/MemJr  control-flow resolution from EX/MEM
//   PCWrite/IfIdWrite/IdExWrite      register load enables
//   IfIdFlush/IdExFlush/ExMemFlush   bubble controls
//   PCSrcSel              0=PC+4, 1=branch, 2=jump, 3=jr
//   MulBusy               multi-cycle op in progress
//   StallCycles/FlushEvents  saturating perf counters, only when the
//                         HAZARD_PERF_CNT_EN macro is defined
module pipeline_hazard_controller
  import hazard_pkg::*;
#(
  parameter int MUL_LATENCY = 4,
  parameter int CNT_W       = 4
)
(
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [4:0]  IfIdRs,
  input  logic [4:0]  IfIdRt,
  input  logic        IfIdUsesRt,
  input  logic        IdExMemRead,
  input  logic [4:0]  IdExRd,
  input  logic        ExMulStart,
  input  logic        MemBranch,
  input  logic        MemZero,
  input  logic        MemJump,
  input  logic        MemJr,
  output logic        PCWrite,
  output logic        IfIdWrite,
  output logic        IdExWrite,
  output logic        IfIdFlush,
  output logic        IdExFlush,
  output logic        ExMemFlush,
  output logic [1:0]  PCSrcSel,
  output logic        MulBusy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] StallCycles,
  output logic [31:0] FlushEvents
`endif
);

  // Entry cycle counts as the first hold, so MULTI covers the remaining
  // MUL_LATENCY-2 holds. With MUL_LATENCY=2 the entry cycle alone suffices.
  localparam logic [CNT_W-1:0] CNT_LOAD    = CNT_W'(MUL_LATENCY - 2);
  localparam state_t           ENTRY_STATE = (MUL_LATENCY > 2) ? MULTI : RUN;

  state_t           r_state;
  state_t           w_nextState;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_nextCnt;
  logic             w_taken;
  logic             w_loadUse;

  assign w_taken = (MemBranch && MemZero) || MemJump || MemJr;

  load_use_detector u_loadUse (
    .i_idExMemRead (IdExMemRead),
    .i_idExRd      (IdExRd),
    .i_ifIdRs      (IfIdRs),
    .i_ifIdRt      (IfIdRt),
    .i_ifIdUsesRt  (IfIdUsesRt),
    .o_loadUse     (w_loadUse)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
    end
  end

  // Outputs are combinational so a hazard is handled in the cycle it is
  // seen. Reset is also decoded here so inputs are ignored while Rst_n is low.
  always_comb begin
    PCWrite     = 1'b1;
    IfIdWrite   = 1'b1;
    IdExWrite   = 1'b1;
    IfIdFlush   = 1'b0;
    IdExFlush   = 1'b0;
    ExMemFlush  = 1'b0;
    PCSrcSel    = PCSRC_SEQ;
    MulBusy     = 1'b0;
    w_nextState = r_state;
    w_nextCnt   = r_cnt;

    if (!Rst_n) begin
      w_nextState = RUN;
      w_nextCnt   = '0;
    end else if (w_taken) begin
      // The multi-cycle op (if any) is younger than the redirecting branch,
      // so it is squashed along with everything else behind MEM.
      if (MemJr) begin
        PCSrcSel = PCSRC_JR;
      end else if (MemJump) begin
        PCSrcSel = PCSRC_J;
      end else begin
        PCSrcSel = PCSRC_BR;
      end
      IfIdFlush   = 1'b1;
      IdExFlush   = 1'b1;
      ExMemFlush  = 1'b1;
      w_nextState = RUN;
      w_nextCnt   = '0;
    end else if (r_state == MULTI) begin
      PCWrite    = 1'b0;
      IfIdWrite  = 1'b0;
      IdExWrite  = 1'b0;
      ExMemFlush = 1'b1;
      MulBusy    = 1'b1;
      if (r_cnt <= CNT_W'(1)) begin
        w_nextState = RUN;
        w_nextCnt   = '0;
      end else begin
        w_nextCnt = r_cnt - CNT_W'(1);
      end
    end else if (ExMulStart) begin
      PCWrite     = 1'b0;
      IfIdWrite   = 1'b0;
      IdExWrite   = 1'b0;
      ExMemFlush  = 1'b1;
      MulBusy     = 1'b1;
      w_nextState = ENTRY_STATE;
      w_nextCnt   = CNT_LOAD;
    end else if (w_loadUse) begin
      PCWrite   = 1'b0;
      IfIdWrite = 1'b0;
      IdExFlush = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stallCycles;
  logic [31:0] r_flushEvents;

  // Saturating counters; they stop at all-ones instead of wrapping.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_stallCycles <= '0;
      r_flushEvents <= '0;
    end else begin
      if (!PCWrite && (r_stallCycles != 32'hFFFF_FFFF)) begin
        r_stallCycles <= r_stallCycles + 32'd1;
      end
      if (w_taken && (r_flushEvents != 32'hFFFF_FFFF)) begin
        r_flushEvents <= r_flushEvents + 32'd1;
      end
    end
  end

  assign StallCycles = r_stallCycles;
  assign FlushEvents = r_flushEvents;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller
// Directed bench for pipeline_hazard_controller (MUL_LATENCY=4). A table of
// single-cycle RUN-state vectors plus hand-written multi-cycle sequences.
// Outputs are compared as one packed word:
//   {PCWrite,IfIdWrite,IdExWrite,IfIdFlush,IdExFlush,ExMemFlush,PCSrcSel,MulBusy}
module tb_pipeline_hazard_controller;

  logic        Clk;
  logic        Rst_n;
  logic [4:0]  IfIdRs;
  logic [4:0]  IfIdRt;
  logic        IfIdUsesRt;
  logic        IdExMemRead;
  logic [4:0]  IdExRd;
  logic        ExMulStart;
  logic        MemBranch;
  logic        MemZero;
  logic        MemJump;
  logic        MemJr;
  logic        PCWrite;
  logic        IfIdWrite;
  logic        IdExWrite;
  logic        IfIdFlush;
  logic        IdExFlush;
  logic        ExMemFlush;
  logic [1:0]  PCSrcSel;
  logic        MulBusy;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] StallCycles;
  logic [31:0] FlushEvents;
`endif

  localparam logic [8:0] EXP_RUN  = 9'b111_000_00_0;
  localparam logic [8:0] EXP_BR   = 9'b111_111_01_0;
  localparam logic [8:0] EXP_J    = 9'b111_111_10_0;
  localparam logic [8:0] EXP_JR   = 9'b111_111_11_0;
  localparam logic [8:0] EXP_LU   = 9'b001_010_00_0;
  localparam logic [8:0] EXP_HOLD = 9'b000_001_00_1;

  typedef struct {
    string      name;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       usesRt;
    logic       memRead;
    logic [4:0] rd;
    logic       branch;
    logic       zero;
    logic       jump;
    logic       jr;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   errors;
  logic [8:0] outVec;

  assign outVec = {PCWrite, IfIdWrite, IdExWrite, IfIdFlush, IdExFlush,
                   ExMemFlush, PCSrcSel, MulBusy};

  pipeline_hazard_controller #(
    .MUL_LATENCY (4),
    .CNT_W       (4)
  ) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .IfIdRs      (IfIdRs),
    .IfIdRt      (IfIdRt),
    .IfIdUsesRt  (IfIdUsesRt),
    .IdExMemRead (IdExMemRead),
    .IdExRd      (IdExRd),
    .ExMulStart  (ExMulStart),
    .MemBranch   (MemBranch),
    .MemZero     (MemZero),
    .MemJump     (MemJump),
    .MemJr       (MemJr),
    .PCWrite     (PCWrite),
    .IfIdWrite   (IfIdWrite),
    .IdExWrite   (IdExWrite),
    .IfIdFlush   (IfIdFlush),
    .IdExFlush   (IdExFlush),
    .ExMemFlush  (ExMemFlush),
    .PCSrcSel    (PCSrcSel),
    .MulBusy     (MulBusy)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .StallCycles (StallCycles),
    .FlushEvents (FlushEvents)
`endif
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic clearInputs();
    IfIdRs      = 5'd0;
    IfIdRt      = 5'd0;
    IfIdUsesRt  = 1'b0;
    IdExMemRead = 1'b0;
    IdExRd      = 5'd0;
    ExMulStart  = 1'b0;
    MemBranch   = 1'b0;
    MemZero     = 1'b0;
    MemJump     = 1'b0;
    MemJr       = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    IfIdRs      = v.rs;
    IfIdRt      = v.rt;
    IfIdUsesRt  = v.usesRt;
    IdExMemRead = v.memRead;
    IdExRd      = v.rd;
    ExMulStart  = 1'b0;
    MemBranch   = v.branch;
    MemZero     = v.zero;
    MemJump     = v.jump;
    MemJr       = v.jr;
  endtask

  task automatic setLoadUse();
    IdExMemRead = 1'b1;
    IdExRd      = 5'd8;
    IfIdRs      = 5'd8;
  endtask

  task automatic checkOutput(input string name, input logic [8:0] exp);
    checks++;
    if (outVec !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, outVec, exp);
    end
  endtask

  task automatic checkCount(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge; inputs change here
  // and are sampled 3 units later, well clear of both clock edges.
  task automatic stepCycle();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    vecs.push_back('{"idle",        5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, EXP_RUN});
    vecs.push_back('{"lu_rs",       5'd8, 5'd2, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, EXP_LU});
    vecs.push_back('{"lu_rd0",      5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, EXP_RUN});
    vecs.push_back('{"lu_rt",       5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, EXP_LU});
    vecs.push_back('{"rt_unused",   5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, EXP_RUN});
    vecs.push_back('{"no_load",     5'd8, 5'd8, 1'b1, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, EXP_RUN});
    vecs.push_back('{"br_taken",    5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, EXP_BR});
    vecs.push_back('{"br_nottaken", 5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, EXP_RUN});
    vecs.push_back('{"jump",        5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, EXP_J});
    vecs.push_back('{"jr_and_jump", 5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, EXP_JR});
    vecs.push_back('{"br_over_lu",  5'd8, 5'd2, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, EXP_BR});
    vecs.push_back('{"zero_only",   5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, EXP_RUN});

    // Reset held: noisy hazard inputs must be ignored.
    Rst_n = 1'b0;
    clearInputs();
    setLoadUse();
    MemBranch = 1'b1;
    MemZero   = 1'b1;
    #3;
    checkOutput("reset_defaults", EXP_RUN);
    @(negedge Clk);
    clearInputs();
    Rst_n = 1'b1;
`ifdef HAZARD_PERF_CNT_EN
    #1;
    checkCount("stall_cnt_reset", StallCycles, 32'd0);
    checkCount("flush_cnt_reset", FlushEvents, 32'd0);
`endif

    // One load-use stall, one 4-cycle multi op (3 holds), one branch.
    stepCycle();
    setLoadUse();
    #3 checkOutput("seq_lu", EXP_LU);
    stepCycle();
    clearInputs();
    ExMulStart = 1'b1;
    #3 checkOutput("mul_hold1", EXP_HOLD);
    stepCycle();
    ExMulStart = 1'b0;
    #3 checkOutput("mul_hold2", EXP_HOLD);
    stepCycle();
    #3 checkOutput("mul_hold3", EXP_HOLD);
    stepCycle();
    MemBranch = 1'b1;
    MemZero   = 1'b1;
    #3 checkOutput("seq_branch", EXP_BR);
    stepCycle();
    clearInputs();
    #3 checkOutput("after_branch", EXP_RUN);
`ifdef HAZARD_PERF_CNT_EN
    checkCount("stall_cycles", StallCycles, 32'd4);
    checkCount("flush_events", FlushEvents, 32'd1);
`endif

    // Table of single-cycle RUN-state vectors.
    foreach (vecs[i]) begin
      stepCycle();
      applyStimulus(vecs[i]);
      #3 checkOutput(vecs[i].name, vecs[i].exp);
    end
    stepCycle();
    clearInputs();

    // Multi op with ExMulStart left high and a load-use pattern during hold:
    // both must be ignored while MULTI owns the pipeline.
    stepCycle();
    ExMulStart = 1'b1;
    #3 checkOutput("mul2_hold1", EXP_HOLD);
    stepCycle();
    #3 checkOutput("mul2_hold2_start_high", EXP_HOLD);
    stepCycle();
    ExMulStart = 1'b0;
    setLoadUse();
    #3 checkOutput("mul2_hold3_lu_masked", EXP_HOLD);
    stepCycle();
    clearInputs();
    #3 checkOutput("mul2_done", EXP_RUN);

    // Redirect on the second hold cycle aborts the multi op.
    stepCycle();
    ExMulStart = 1'b1;
    #3 checkOutput("mul3_hold1", EXP_HOLD);
    stepCycle();
    ExMulStart = 1'b0;
    MemJump    = 1'b1;
    #3 checkOutput("mul3_jump_abort", EXP_J);
    stepCycle();
    clearInputs();
    #3 checkOutput("mul3_after_abort", EXP_RUN);
    stepCycle();
    #3 checkOutput("mul3_stays_run", EXP_RUN);

    // Asynchronous reset in the middle of a multi op.
    stepCycle();
    ExMulStart = 1'b1;
    #3 checkOutput("mul4_hold1", EXP_HOLD);
    stepCycle();
    ExMulStart = 1'b0;
    #2 checkOutput("mul4_hold2", EXP_HOLD);
    Rst_n = 1'b0;
    #1 checkOutput("mid_cycle_reset", EXP_RUN);
    @(negedge Clk);
    Rst_n = 1'b1;
    #1 checkOutput("reset_release_run", EXP_RUN);
    stepCycle();
    #3 checkOutput("post_reset_run", EXP_RUN);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
